div16_8_seq: RTL and testbench

Sequential 16-by-8 unsigned divider: the inverse of the 8x8 multipliers in this library. It takes a 16-bit dividend (a product word) and an 8-bit divisor, and returns an 8-bit quotient, an 8-bit remainder and status flags. It uses radix-2 restoring division, one quotient bit per cycle, behind valid/ready handshakes on both sides. It sits in the characterization datapath, where it recovers operands from exact or approximate products.

---
 rtl/div16_8_seq.sv | 133 +++++++++++++
 tb/tb_div16_8_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div16_8_seq.sv
// div16_8_seq: 16-by-8 unsigned restoring divider producing one quotient bit per cycle,
// with valid/ready handshakes on both the operand and the result side.
`timescale 1ns/1ps
module div16_8_seq #(
  parameter int EARLY_OUT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  Q,
  output logic [7:0]  R,
  output logic        OVF,
  output logic        DZ
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] iter_cnt;
  logic [7:0] a_lo;
  logic [7:0] b_reg;
  logic [7:0] quot;
  logic [8:0] p_reg;
  logic       is_dz;
  logic       is_ovf;
  logic       accept;
  logic       finish;
  logic       special;
  logic       next_bit;
  logic [9:0] trial;
  logic [8:0] p_next;
  logic [7:0] quot_next;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign special  = is_dz | is_ovf;
  // Special operands still spend one cycle in DIV so the result appears one edge after accept.
  assign finish   = (state == DIV) &&
                    ((iter_cnt == 3'd7) || (special && (EARLY_OUT != 0)));

  // One restoring step: shift in the next dividend bit and try subtracting the divisor.
  always_comb begin
    next_bit  = a_lo[3'd7 - iter_cnt];
    trial     = {1'b0, p_reg[7:0], next_bit} - {2'b00, b_reg};
    p_next    = trial[8:0];
    quot_next = {quot[6:0], 1'b1};
    if (trial[9]) begin
      p_next    = {p_reg[7:0], next_bit};
      quot_next = {quot[6:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = DIV;
      DIV:  if (finish) state_next = DONE;
      DONE: if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt  <= 3'd0;
      a_lo      <= 8'd0;
      b_reg     <= 8'd0;
      quot      <= 8'd0;
      p_reg     <= 9'd0;
      is_dz     <= 1'b0;
      is_ovf    <= 1'b0;
      out_valid <= 1'b0;
      Q         <= 8'd0;
      R         <= 8'd0;
      OVF       <= 1'b0;
      DZ        <= 1'b0;
    end else begin
      if (accept) begin
        a_lo     <= A[7:0];
        b_reg    <= B;
        p_reg    <= {1'b0, A[15:8]};
        quot     <= 8'd0;
        iter_cnt <= 3'd0;
        is_dz    <= (B == 8'd0);
        is_ovf   <= (B != 8'd0) && (A[15:8] >= B);
      end
      if (state == DIV) begin
        p_reg    <= p_next;
        quot     <= quot_next;
        iter_cnt <= iter_cnt + 3'd1;
      end
      // Results are only ever written here, so they hold through any back-pressure.
      if (finish) begin
        iter_cnt  <= 3'd0;
        out_valid <= 1'b1;
        if (is_dz) begin
          Q   <= 8'hFF;
          R   <= a_lo;
          DZ  <= 1'b1;
          OVF <= 1'b0;
        end else if (is_ovf) begin
          Q   <= 8'hFF;
          R   <= 8'hFF;
          DZ  <= 1'b0;
          OVF <= 1'b1;
        end else begin
          Q   <= quot_next;
          R   <= p_next[7:0];
          DZ  <= 1'b0;
          OVF <= 1'b0;
        end
      end
      if (state == DONE && out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div16_8_seq.sv
// tb_div16_8_seq: directed and randomized checks of div16_8_seq, with EARLY_OUT
// enabled on one instance and disabled on the other.
`timescale 1ns/1ps
module tb_div16_8_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_e = 1'b0;
  logic        in_valid_c = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a_in = 16'd0;
  logic [7:0]  b_in = 8'd0;

  logic        in_ready_e, out_valid_e, ovf_e, dz_e;
  logic [7:0]  q_e, r_e;
  logic        in_ready_c, out_valid_c, ovf_c, dz_c;
  logic [7:0]  q_c, r_c;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div16_8_seq #(.EARLY_OUT(1)) dut_early (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_e), .in_ready(in_ready_e),
    .A(a_in), .B(b_in), .out_valid(out_valid_e), .out_ready(out_ready),
    .Q(q_e), .R(r_e), .OVF(ovf_e), .DZ(dz_e)
  );

  div16_8_seq #(.EARLY_OUT(0)) dut_const (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .A(a_in), .B(b_in), .out_valid(out_valid_c), .out_ready(out_ready),
    .Q(q_c), .R(r_c), .OVF(ovf_c), .DZ(dz_c)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  function automatic logic sel_valid(input bit sel);
    return sel ? out_valid_c : out_valid_e;
  endfunction

  function automatic logic sel_ready(input bit sel);
    return sel ? in_ready_c : in_ready_e;
  endfunction

  function automatic logic [17:0] sel_result(input bit sel);
    return sel ? {q_c, r_c, ovf_c, dz_c} : {q_e, r_e, ovf_e, dz_e};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Full transaction: wait for in_ready, accept, measure latency, stall, transfer.
  task automatic applyStimulus(input bit sel, input logic [15:0] a, input logic [7:0] b,
                               input int stall, output logic [7:0] q, output logic [7:0] r,
                               output logic ovf, output logic dz, output int lat);
    int n;
    logic [17:0] res;
    @(negedge clk);
    n = 0;
    while (!sel_ready(sel) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) checkOutput("ready_timeout", 32'(n), 32'd0);
    a_in = a;
    b_in = b;
    if (sel) in_valid_c = 1'b1; else in_valid_e = 1'b1;
    @(posedge clk);
    #1;
    in_valid_e = 1'b0;
    in_valid_c = 1'b0;
    lat = 0;
    while (!sel_valid(sel) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = sel_result(sel);
    {q, r, ovf, dz} = res;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_result", 32'(sel_result(sel)), 32'(res));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("xfer_valid", 32'(sel_valid(sel)), 32'd0);
    checkOutput("xfer_ready", 32'(sel_ready(sel)), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] q, r;
    logic ovf, dz;
    int lat, n;
    logic [15:0] ra;
    logic [7:0] rb;

    vecs[0]  = '{16'd12345, 8'd100, 8'd123, 8'd45,  1'b0, 1'b0, 8};
    vecs[1]  = '{16'hFEFF,  8'hFF,  8'd255, 8'd254, 1'b0, 1'b0, 8};
    vecs[2]  = '{16'hFF00,  8'hFF,  8'hFF,  8'hFF,  1'b1, 1'b0, 1};
    vecs[3]  = '{16'h1234,  8'h00,  8'hFF,  8'h34,  1'b0, 1'b1, 1};
    vecs[4]  = '{16'd30000, 8'd200, 8'd150, 8'd0,   1'b0, 1'b0, 8};
    vecs[5]  = '{16'd0,     8'd1,   8'd0,   8'd0,   1'b0, 1'b0, 8};
    vecs[6]  = '{16'h00FF,  8'h10,  8'd15,  8'd15,  1'b0, 1'b0, 8};
    vecs[7]  = '{16'h0100,  8'd1,   8'hFF,  8'hFF,  1'b1, 1'b0, 1};
    vecs[8]  = '{16'h00FF,  8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 8};
    vecs[9]  = '{16'd1000,  8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 8};
    vecs[10] = '{16'd0,     8'd0,   8'hFF,  8'h00,  1'b0, 1'b1, 1};

    // Reset state, checked while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready_e), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid_e), 32'd0);
    checkOutput("rst_q", 32'(q_e), 32'd0);
    checkOutput("rst_r", 32'(r_e), 32'd0);
    checkOutput("rst_flags", 32'({ovf_e, dz_e}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(in_ready_e), 32'd1);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, vecs[i].a, vecs[i].b, i % 3, q, r, ovf, dz, lat);
      checkOutput($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      checkOutput($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
      checkOutput($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      checkOutput($sformatf("vec%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Constant-latency instance: special cases still take 8 cycles.
    applyStimulus(1'b1, 16'h1234, 8'h00, 0, q, r, ovf, dz, lat);
    checkOutput("const_dz_lat", 32'(lat), 32'd8);
    checkOutput("const_dz_res", 32'({q, r, ovf, dz}), 32'({8'hFF, 8'h34, 1'b0, 1'b1}));
    applyStimulus(1'b1, 16'hFF00, 8'hFF, 1, q, r, ovf, dz, lat);
    checkOutput("const_ovf_lat", 32'(lat), 32'd8);
    checkOutput("const_ovf_res", 32'({q, r, ovf, dz}), 32'({8'hFF, 8'hFF, 1'b1, 1'b0}));
    applyStimulus(1'b1, 16'd12345, 8'd100, 2, q, r, ovf, dz, lat);
    checkOutput("const_norm_lat", 32'(lat), 32'd8);
    checkOutput("const_norm_res", 32'({q, r, ovf, dz}), 32'({8'd123, 8'd45, 1'b0, 1'b0}));

    // Back-pressure with a competing request that must be ignored.
    @(negedge clk);
    a_in = 16'd12345;
    b_in = 8'd100;
    in_valid_e = 1'b1;
    @(posedge clk);
    #1;
    in_valid_e = 1'b0;
    n = 0;
    while (!out_valid_e && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("bp_lat", 32'(n), 32'd8);
    a_in = 16'd1000;
    b_in = 8'd7;
    in_valid_e = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_q", 32'(q_e), 32'd123);
      checkOutput("bp_r", 32'(r_e), 32'd45);
      checkOutput("bp_valid", 32'(out_valid_e), 32'd1);
      checkOutput("bp_ready", 32'(in_ready_e), 32'd0);
    end
    in_valid_e = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_xfer_valid", 32'(out_valid_e), 32'd0);
    checkOutput("bp_xfer_ready", 32'(in_ready_e), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_no_accept", 32'(in_ready_e), 32'd1);

    // out_ready already high: transfer on the first edge with out_valid.
    @(negedge clk);
    out_ready = 1'b1;
    a_in = 16'h00FF;
    b_in = 8'h10;
    in_valid_e = 1'b1;
    @(posedge clk);
    #1;
    in_valid_e = 1'b0;
    n = 0;
    while (!out_valid_e && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("early_rdy_lat", 32'(n), 32'd8);
    checkOutput("early_rdy_q", 32'(q_e), 32'd15);
    @(posedge clk);
    #1;
    checkOutput("early_rdy_xfer", 32'(out_valid_e), 32'd0);
    out_ready = 1'b0;

    // Reset during iteration 4 aborts the operation.
    @(negedge clk);
    a_in = 16'd30000;
    b_in = 8'd200;
    in_valid_e = 1'b1;
    @(posedge clk);
    #1;
    in_valid_e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid_e), 32'd0);
    checkOutput("midrst_q", 32'(q_e), 32'd0);
    checkOutput("midrst_r", 32'(r_e), 32'd0);
    checkOutput("midrst_flags", 32'({ovf_e, dz_e}), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready_e), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'd30000, 8'd200, 0, q, r, ovf, dz, lat);
    checkOutput("after_rst_q", 32'(q), 32'd150);
    checkOutput("after_rst_r", 32'(r), 32'd0);
    checkOutput("after_rst_lat", 32'(lat), 32'd8);

    // Round trip of exact products on a coarse grid.
    for (int a = 1; a <= 255; a += 17) begin
      for (int b = 1; b <= 255; b += 13) begin
        applyStimulus(1'b0, 16'(a * b), 8'(b), 0, q, r, ovf, dz, lat);
        checkOutput($sformatf("rt_%0dx%0d_q", a, b), 32'(q), 32'(a));
        checkOutput($sformatf("rt_%0dx%0d_r", a, b), 32'(r), 32'd0);
      end
    end

    // Random operands with random idle gaps and output stalls.
    for (int i = 0; i < 150; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(0, 255));
      if (i % 2 == 0) ra[15:8] = 8'(ra[15:8] % (rb == 8'd0 ? 9'd256 : {1'b0, rb}));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(1'b0, ra, rb, $urandom_range(0, 3), q, r, ovf, dz, lat);
      if (rb == 8'd0) begin
        checkOutput("rand_dz", 32'({q, r, ovf, dz, 8'(lat)}), 32'({8'hFF, ra[7:0], 1'b0, 1'b1, 8'd1}));
      end else if (ra[15:8] >= rb) begin
        checkOutput("rand_ovf", 32'({q, r, ovf, dz, 8'(lat)}), 32'({8'hFF, 8'hFF, 1'b1, 1'b0, 8'd1}));
      end else begin
        checkOutput("rand_norm", 32'({q, r, ovf, dz, 8'(lat)}),
                    32'({8'(ra / rb), 8'(ra % rb), 1'b0, 1'b0, 8'd8}));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
